// File: rtl/mux_link_pkg.sv
// Shared definitions for the 4:1 time-division link (mux and demux ends).
package mux_link_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

endpackage

// File: rtl/demux14_tdm.sv
// Splits a 4-slot TDM line into four channels; o/frame_valid update the cycle after the slot-3 beat.
// No backpressure: every valid beat is consumed; din_valid gaps simply hold state.
module demux14_tdm
  import mux_link_pkg::*;
#(
  parameter int W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              sof,
  output logic [N_CH*W-1:0] o,
  output logic [SEL_W-1:0]  sel,
  output logic              frame_valid,
  output logic              frame_err
);

  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [W-1:0]        r_sh0;
  logic [W-1:0]        r_sh1;
  logic [W-1:0]        r_sh2;
  logic [N_CH*W-1:0]   r_o;
  logic                r_frame_valid;
  logic                r_frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sel         <= '0;
      r_sh0         <= '0;
      r_sh1         <= '0;
      r_sh2         <= '0;
      r_o           <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (din_valid) begin
        case (r_state)
          IDLE: begin
            // Unsynchronised beats are dropped until a start of frame shows up.
            if (sof) begin
              r_sh0   <= din;
              r_sel   <= 2'd1;
              r_state <= RUN;
            end
          end
          RUN: begin
            if (sof) begin
              // sof mid-frame resyncs on this beat; sof at slot 0 is the normal case.
              r_frame_err <= (r_sel != 2'd0);
              r_sh0       <= din;
              r_sel       <= 2'd1;
            end else begin
              case (r_sel)
                2'd0: begin
                  r_frame_err <= 1'b1;
                  r_state     <= IDLE;
                end
                2'd1: begin
                  r_sh1 <= din;
                  r_sel <= 2'd2;
                end
                2'd2: begin
                  r_sh2 <= din;
                  r_sel <= 2'd3;
                end
                default: begin
                  r_o           <= {din, r_sh2, r_sh1, r_sh0};
                  r_frame_valid <= 1'b1;
                  r_sel         <= 2'd0;
                end
              endcase
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o           = r_o;
  assign sel         = r_sel;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_demux14_tdm.sv
// Bench for demux14_tdm: directed frames with literal expectations plus randomized traffic vs a queue model.
module tb_demux14_tdm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sof = 1'b0;
  logic [3:0] o;
  logic [1:0] sel;
  logic       frame_valid;
  logic       frame_err;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Behavioural model: beats collected so far in the current frame.
  bit         m_synced = 1'b0;
  logic       m_beats[$];
  logic [3:0] m_o  = 4'd0;
  bit         m_fv = 1'b0;
  bit         m_fe = 1'b0;

  demux14_tdm #(.W(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .o          (o),
    .sel        (sel),
    .frame_valid(frame_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  always @(posedge clk) begin
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (rst) begin
      m_synced = 1'b0;
      m_beats.delete();
      m_o = 4'd0;
    end else if (din_valid) begin
      if (sof) begin
        if (m_synced && m_beats.size() != 0) m_fe = 1'b1;
        m_beats.delete();
        m_beats.push_back(din[0]);
        m_synced = 1'b1;
      end else if (!m_synced) begin
        // dropped
      end else if (m_beats.size() == 0) begin
        m_fe = 1'b1;
        m_synced = 1'b0;
      end else begin
        m_beats.push_back(din[0]);
        if (m_beats.size() == 4) begin
          m_o  = {m_beats[3], m_beats[2], m_beats[1], m_beats[0]};
          m_fv = 1'b1;
          m_beats.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_o", {28'd0, o}, {28'd0, m_o});
      chk("model_sel", {30'd0, sel}, m_beats.size() % 4);
      chk("model_fv", {31'd0, frame_valid}, {31'd0, m_fv});
      chk("model_fe", {31'd0, frame_err}, {31'd0, m_fe});
    end
  end

  task automatic beat(input logic d, input logic s);
    din       = d;
    sof       = s;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] pat;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_o", {28'd0, o}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_fv", {31'd0, frame_valid}, 32'd0);
    chk("rst_fe", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;

    // Frame 1,0,1,1 back to back.
    beat(1'b1, 1'b1); chk("t1_sel1", {30'd0, sel}, 32'd1);
    beat(1'b0, 1'b0); chk("t1_sel2", {30'd0, sel}, 32'd2);
    beat(1'b1, 1'b0); chk("t1_sel3", {30'd0, sel}, 32'd3);
    chk("t1_o_hold", {28'd0, o}, 32'd0);
    beat(1'b1, 1'b0); chk("t1_sel0", {30'd0, sel}, 32'd0);
    chk("t1_o", {28'd0, o}, 32'hD);
    chk("t1_fv", {31'd0, frame_valid}, 32'd1);
    gap(1);
    chk("t1_fv_once", {31'd0, frame_valid}, 32'd0);

    // Same frame with gaps; sof without din_valid must be ignored.
    sof = 1'b1;
    gap(1);
    sof = 1'b0;
    chk("t2_sof_ign", {31'd0, frame_err}, 32'd0);
    beat(1'b1, 1'b1); gap(2);
    chk("t2_sel_hold", {30'd0, sel}, 32'd1);
    beat(1'b0, 1'b0); gap(2);
    beat(1'b1, 1'b0); gap(2);
    beat(1'b1, 1'b0);
    chk("t2_o", {28'd0, o}, 32'hD);
    chk("t2_fv", {31'd0, frame_valid}, 32'd1);

    // Beats before any sof after reset.
    do_reset();
    beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    chk("t3_noerr", {31'd0, frame_err}, 32'd0);
    chk("t3_o0", {28'd0, o}, 32'd0);
    chk("t3_sel0", {30'd0, sel}, 32'd0);
    beat(1'b0, 1'b1); beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    chk("t3_o", {28'd0, o}, 32'h2);

    // Early sof on third beat.
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b1);
    chk("t4_fe", {31'd0, frame_err}, 32'd1);
    chk("t4_o_keep", {28'd0, o}, 32'h2);
    chk("t4_sel", {30'd0, sel}, 32'd1);
    beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    chk("t4_o", {28'd0, o}, 32'hF);

    // Lost sync at slot 0, then recovery.
    beat(1'b0, 1'b0);
    chk("t5_fe", {31'd0, frame_err}, 32'd1);
    chk("t5_o_keep", {28'd0, o}, 32'hF);
    beat(1'b1, 1'b0);
    chk("t5_idle_noerr", {31'd0, frame_err}, 32'd0);
    beat(1'b0, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    chk("t5_o", {28'd0, o}, 32'hC);

    // Reset mid-frame.
    beat(1'b1, 1'b1); beat(1'b1, 1'b0);
    do_reset();
    chk("t6_o_rst", {28'd0, o}, 32'd0);
    chk("t6_sel_rst", {30'd0, sel}, 32'd0);
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0);
    chk("t6_o", {28'd0, o}, 32'h9);
    chk("t6_fv", {31'd0, frame_valid}, 32'd1);
    gap(1);
    chk("t6_fv_once", {31'd0, frame_valid}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      pat       = 4'($urandom_range(0, 15));
      din       = pat[0];
      din_valid = ($urandom_range(0, 9) < 7);
      if (m_beats.size() == 0)
        sof = ($urandom_range(0, 9) != 0);
      else
        sof = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    din_valid = 1'b0;
    sof       = 1'b0;
    gap(2);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
